frame_mem_responder: RTL and testbench



---
 rtl/frame_mem_pkg.sv | 24 ++
 rtl/frame_mem_dpram.sv | 38 +++
 rtl/frame_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_frame_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_mem_pkg.sv
// frame_mem_pkg: shared types and constants for frame_mem_responder.
//   DATA_W / ADDR_W : bus widths
//   LAT_W           : width of the wait-state counters (latency 0..15)
//   wr_state_t / rd_state_t : write / read handshake FSM states
//   lat_load()      : initial wait-counter value for a given latency
package frame_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LAT_W  = 4;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACK} rd_state_t;

  // The counter is loaded with lat-1 so that *_WAIT lasts exactly lat cycles
  // (the cycle that sees zero is the last wait cycle).
  function automatic logic [LAT_W-1:0] lat_load(input int unsigned lat);
    logic [LAT_W-1:0] v;
    v = '0;
    if (lat != 0) v = LAT_W'(lat - 1);
    return v;
  endfunction

endpackage

// File: rtl/frame_mem_dpram.sv
// frame_mem_dpram: DEPTH x DATA_W simple dual-port RAM.
//   clk   : clock
//   rst   : async active-high reset (clears the read register only)
//   we    : write enable, waddr / wdata : write port
//   re    : read enable,  raddr / rdata : registered read port
// A same-edge write and read of one word returns the new data (write-first).
module frame_mem_dpram
  import frame_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array kept out of any reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/frame_mem_responder.sv
// frame_mem_responder: memory slave with independent write and read
// waitrequest handshakes, each inserting a fixed number of wait cycles.
//   ctrl_clk, reset          : clock, async active-high reset
//   write_addr, iData, write : write request (byte address, data)
//   write_waitrequest        : low for exactly the completing cycle
//   read_addr, read          : read request (byte address)
//   oData, read_waitrequest  : read data (held until next read), handshake
//   wr_count, rd_count       : completed-access counters
//   proto_err                : sticky request-changed-during-wait flag
// Macro FRAME_MEM_RESPONDER_STATS_EN enables wr_count/rd_count/proto_err;
// without it those outputs are tied to zero.
module frame_mem_responder
  import frame_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WR_LAT = 2,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] iData,
  input  logic              write,
  output logic              write_waitrequest,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read,
  output logic [DATA_W-1:0] oData,
  output logic              read_waitrequest,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              proto_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  wr_state_t         wr_state;
  logic [LAT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_fire;

  rd_state_t         rd_state;
  logic [LAT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_fire;

  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_waddr;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_wdata;

  // *_fire is true on the edge that enters *_ACK. The RAM write and the oData
  // capture both happen on that edge, so equal-latency accesses to the same
  // word collide in the RAM and the write-first bypass resolves them.
  always_comb begin
    wr_fire = 1'b0;
    case (wr_state)
      W_IDLE:  wr_fire = write && (WR_LAT == 0);
      W_WAIT:  wr_fire = (wr_cnt == '0);
      default: wr_fire = 1'b0;
    endcase
  end

  always_comb begin
    rd_fire = 1'b0;
    case (rd_state)
      R_IDLE:  rd_fire = read && (RD_LAT == 0);
      R_WAIT:  rd_fire = (rd_cnt == '0);
      default: rd_fire = 1'b0;
    endcase
  end

  // Zero-latency accesses fire straight from IDLE, before the capture
  // registers are loaded, so the RAM ports take the live inputs there.
  always_comb begin
    ram_we    = wr_fire && !reset;
    ram_re    = rd_fire && !reset;
    ram_waddr = (wr_state == W_IDLE) ? write_addr[IDX_W+1:2] : wr_addr_q[IDX_W+1:2];
    ram_wdata = (wr_state == W_IDLE) ? iData : wr_data_q;
    ram_raddr = (rd_state == R_IDLE) ? read_addr[IDX_W+1:2] : rd_addr_q[IDX_W+1:2];
  end

  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      wr_state          <= W_IDLE;
      wr_cnt            <= '0;
      wr_addr_q         <= '0;
      wr_data_q         <= '0;
      write_waitrequest <= 1'b1;
    end else begin
      write_waitrequest <= !wr_fire;
      case (wr_state)
        W_IDLE: begin
          if (write) begin
            wr_addr_q <= write_addr;
            wr_data_q <= iData;
            wr_cnt    <= lat_load(WR_LAT);
            wr_state  <= (WR_LAT == 0) ? W_ACK : W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_cnt == '0) wr_state <= W_ACK;
          else              wr_cnt   <= wr_cnt - 1'b1;
        end
        W_ACK:   wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      rd_state         <= R_IDLE;
      rd_cnt           <= '0;
      rd_addr_q        <= '0;
      read_waitrequest <= 1'b1;
    end else begin
      read_waitrequest <= !rd_fire;
      case (rd_state)
        R_IDLE: begin
          if (read) begin
            rd_addr_q <= read_addr;
            rd_cnt    <= lat_load(RD_LAT);
            rd_state  <= (RD_LAT == 0) ? R_ACK : R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == '0) rd_state <= R_ACK;
          else              rd_cnt   <= rd_cnt - 1'b1;
        end
        R_ACK:   rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  frame_mem_dpram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (ctrl_clk),
    .rst   (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (oData)
  );

`ifdef FRAME_MEM_RESPONDER_STATS_EN
  logic wr_violation;
  logic rd_violation;

  always_comb begin
    wr_violation = (wr_state == W_WAIT) &&
                   (!write || (write_addr != wr_addr_q) || (iData != wr_data_q));
    rd_violation = (rd_state == R_WAIT) &&
                   (!read || (read_addr != rd_addr_q));
  end

  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      wr_count  <= '0;
      rd_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr_state == W_ACK) wr_count <= wr_count + 1'b1;
      if (rd_state == R_ACK) rd_count <= rd_count + 1'b1;
      if (wr_violation || rd_violation) proto_err <= 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{wr_addr_q[ADDR_W-1:IDX_W+2], wr_addr_q[1:0],
                       rd_addr_q[ADDR_W-1:IDX_W+2], rd_addr_q[1:0]};
  assign wr_count  = '0;
  assign rd_count  = '0;
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_mem_responder.sv
// Directed bench for frame_mem_responder. u_dut uses default parameters;
// u_dut_eq uses WR_LAT=RD_LAT=2 for the simultaneous write/read collision.
module tb_frame_mem_responder;

  logic        ctrl_clk = 1'b0;
  logic        reset;
  logic [31:0] write_addr, iData, read_addr, oData;
  logic        write, read, write_waitrequest, read_waitrequest, proto_err;
  logic [15:0] wr_count, rd_count;

  logic [31:0] b_write_addr, b_iData, b_read_addr, b_oData;
  logic        b_write, b_read, b_write_waitrequest, b_read_waitrequest, b_proto_err;
  logic [15:0] b_wr_count, b_rd_count;

  int checks   = 0;
  int failures = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  frame_mem_responder u_dut (
    .ctrl_clk          (ctrl_clk),
    .reset             (reset),
    .write_addr        (write_addr),
    .iData             (iData),
    .write             (write),
    .write_waitrequest (write_waitrequest),
    .read_addr         (read_addr),
    .read              (read),
    .oData             (oData),
    .read_waitrequest  (read_waitrequest),
    .wr_count          (wr_count),
    .rd_count          (rd_count),
    .proto_err         (proto_err)
  );

  frame_mem_responder #(
    .DEPTH  (32),
    .WR_LAT (2),
    .RD_LAT (2)
  ) u_dut_eq (
    .ctrl_clk          (ctrl_clk),
    .reset             (reset),
    .write_addr        (b_write_addr),
    .iData             (b_iData),
    .write             (b_write),
    .write_waitrequest (b_write_waitrequest),
    .read_addr         (b_read_addr),
    .read              (b_read),
    .oData             (b_oData),
    .read_waitrequest  (b_read_waitrequest),
    .wr_count          (b_wr_count),
    .rd_count          (b_rd_count),
    .proto_err         (b_proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
  endtask

  // Cycle 0 is the cycle in which write is first sampled; returns at the
  // negedge of the cycle after the ack with write already dropped.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat);
    int lat;
    write_addr = a;
    iData      = d;
    write      = 1'b1;
    lat        = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!write_waitrequest) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    tick();
    write = 1'b0;
    check({tag, "_wait_after"}, {31'd0, write_waitrequest}, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_lat);
    int lat;
    read_addr = a;
    read      = 1'b1;
    lat       = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!read_waitrequest) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data_ack"}, oData, exp_d);
    tick();
    read = 1'b0;
    check({tag, "_wait_after"}, {31'd0, read_waitrequest}, 32'd1);
    check({tag, "_data_hold"}, oData, exp_d);
  endtask

  initial begin
    int lat;
    logic [31:0] exp_wc, exp_rc, exp_pe;

    reset = 1'b1;
    write = 1'b0; read = 1'b0;
    write_addr = '0; iData = '0; read_addr = '0;
    b_write = 1'b0; b_read = 1'b0;
    b_write_addr = '0; b_iData = '0; b_read_addr = '0;
    repeat (2) tick();
    check("rst_wwait", {31'd0, write_waitrequest}, 32'd1);
    check("rst_rwait", {31'd0, read_waitrequest}, 32'd1);
    check("rst_odata", oData, 32'h0);
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_rd_count", {16'd0, rd_count}, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic write then read-back with default latencies.
    do_write("wr_8", 32'h8, 32'hDEADBEEF, 3);
    do_read("rd_8", 32'h8, 32'hDEADBEEF, 4);

    // 0x84 and 0x04 share word 1 when DEPTH=32.
    do_write("wr_84", 32'h84, 32'h12345678, 3);
    do_read("rd_04_wrap", 32'h04, 32'h12345678, 4);

    // Simultaneous write/read of one word with equal latency.
    b_write_addr = 32'h40; b_iData = 32'hA5A5A5A5; b_read_addr = 32'h40;
    b_write = 1'b1; b_read = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!b_write_waitrequest || !b_read_waitrequest) begin
        lat = i;
        break;
      end
    end
    check("coll_lat", lat, 3);
    check("coll_wwait", {31'd0, b_write_waitrequest}, 32'd0);
    check("coll_rwait", {31'd0, b_read_waitrequest}, 32'd0);
    check("coll_data", b_oData, 32'hA5A5A5A5);
    tick();
    b_write = 1'b0; b_read = 1'b0;

    // Reset in the middle of a write must abort it without touching RAM.
    do_write("wr_0_prior", 32'h0, 32'hCAFEF00D, 3);
    write_addr = 32'h0; iData = 32'h1; write = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("rstmid_wwait", {31'd0, write_waitrequest}, 32'd1);
    check("rstmid_rwait", {31'd0, read_waitrequest}, 32'd1);
    check("rstmid_odata", oData, 32'h0);
    tick();
    tick();
    write = 1'b0;
    reset = 1'b0;
    tick();
    do_read("rd_0_after_rst", 32'h0, 32'hCAFEF00D, 4);

    // Statistics: fresh reset, 5 clean writes, 1 dropped write, 3 reads.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("st_wr_count0", {16'd0, wr_count}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      do_write("st_wr", 32'h10 + 32'(4 * k), 32'h1000 + 32'(k), 3);
    end
    check("st_proto_clean", {31'd0, proto_err}, 32'd0);
    write_addr = 32'h30; iData = 32'h77; write = 1'b1;
    tick();
    write = 1'b0;
    lat = 1;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (!write_waitrequest) begin
        lat = i;
        break;
      end
    end
    check("drop_lat", lat, 3);
    tick();
    check("drop_wait_after", {31'd0, write_waitrequest}, 32'd1);
    do_read("rd_dropped", 32'h30, 32'h77, 4);
    do_read("rd_st_first", 32'h10, 32'h1000, 4);
    do_read("rd_st_last", 32'h20, 32'h1004, 4);

`ifdef FRAME_MEM_RESPONDER_STATS_EN
    exp_wc = 32'd6; exp_rc = 32'd3; exp_pe = 32'd1;
`else
    exp_wc = 32'd0; exp_rc = 32'd0; exp_pe = 32'd0;
`endif
    check("st_wr_count", {16'd0, wr_count}, exp_wc);
    check("st_rd_count", {16'd0, rd_count}, exp_rc);
    check("st_proto_err", {31'd0, proto_err}, exp_pe);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
